result_formatter: RTL and testbench

Sequential post-processor for the calculator's decimal floating-point results (sign, 34-bit binary mantissa, signed 7-bit power-of-ten exponent). It sits directly downstream of the arithmetic units (adder, multiplier, divider) and consumes their `signRes`/`mantRes`/`expRes` on the `done` pulse. It converts the binary mantissa to 11 BCD digits with a multi-cycle double-dabble, counts significant digits, and produces a scientific-notation exponent for the display driver.

---
 rtl/calc_pkg.sv | 8 +
 rtl/result_formatter_dd_step.sv | 16 +
 rtl/result_formatter.sv | 140 ++++++++++++++
 tb/tb_result_formatter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, limits and formatter state type for the calculator datapath
package calc_pkg;
    localparam int MANT_W = 34;
    localparam int EXP_W  = 7;
    localparam int NDIG   = 11;
    localparam logic [MANT_W-1:0] M_MAX = 34'd17179869183;
    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_FINAL, S_DONE} fmt_state_t;
endpackage

// File: rtl/result_formatter_dd_step.sv
// dd_step: one double-dabble iteration, add-3 correction then shift {bcd, bin} left
module dd_step #(
    parameter int NDIG   = calc_pkg::NDIG,
    parameter int MANT_W = calc_pkg::MANT_W
) (
    input  logic [4*NDIG-1:0] bcd_i,
    input  logic [MANT_W-1:0] bin_i,
    output logic [4*NDIG-1:0] bcd_o,
    output logic [MANT_W-1:0] bin_o
);
    logic [4*NDIG-1:0] adj;
    for (genvar i = 0; i < NDIG; i++) begin : g_nib
        assign adj[4*i+:4] = (bcd_i[4*i+:4] >= 4'd5) ? bcd_i[4*i+:4] + 4'd3 : bcd_i[4*i+:4];
    end
    assign {bcd_o, bin_o} = {adj[4*NDIG-2:0], bin_i, 1'b0};
endmodule

// File: rtl/result_formatter.sv
// result_formatter: converts sign/mantissa/exponent results to BCD digits plus a scientific exponent
module result_formatter #(
    parameter int NDIG   = calc_pkg::NDIG,
    parameter int MANT_W = calc_pkg::MANT_W,
    parameter int EXP_W  = calc_pkg::EXP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              signIn,
    input  logic [MANT_W-1:0] mantIn,
    input  logic [EXP_W-1:0]  expIn,
    output logic              busy,
    output logic              valid,
    output logic              signOut,
    output logic [4*NDIG-1:0] digits,
    output logic [3:0]        nDigits,
    output logic [7:0]        expOut,
    output logic              isZero
);
    import calc_pkg::*;

    function automatic logic [3:0] lead_zeros(input logic [4*NDIG-1:0] b);
        logic [3:0] n;
        logic       f;
        n = '0;
        f = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (!f && b[4*i+:4] == 4'd0) n = n + 4'd1;
            else f = 1'b1;
        end
        return n;
    endfunction

    fmt_state_t        state_q, state_d;
    logic              prev_q, sign_q, sign_d, valid_q, valid_d;
    logic [MANT_W-1:0] mant_q, mant_d, mant_s;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d, bcd_s, digits_q, digits_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              osign_q, osign_d, zero_q, zero_d;
    logic [3:0]        nd_q, nd_d, nd;
    logic [7:0]        eout_q, eout_d;
    logic              go, zr;

    dd_step #(.NDIG(NDIG), .MANT_W(MANT_W)) u_step (
        .bcd_i(bcd_q),
        .bin_i(mant_q),
        .bcd_o(bcd_s),
        .bin_o(mant_s)
    );

    assign go = start && !prev_q;
    assign zr = (bcd_q == '0);
    assign nd = zr ? 4'd1 : 4'(NDIG) - lead_zeros(bcd_q);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        osign_d  = osign_q;
        digits_d = digits_q;
        nd_d     = nd_q;
        eout_d   = eout_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: if (go) begin
                sign_d  = signIn;
                mant_d  = mantIn;
                exp_d   = expIn;
                bcd_d   = '0;
                cnt_d   = 6'(MANT_W);
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                bcd_d   = bcd_s;
                mant_d  = mant_s;
                cnt_d   = cnt_q - 6'd1;
                state_d = (cnt_q == 6'd1) ? S_FINAL : S_CONVERT;
            end
            S_FINAL: begin
                digits_d = bcd_q;
                osign_d  = sign_q & ~zr;
                zero_d   = zr;
                nd_d     = nd;
                eout_d   = zr ? 8'd0 : {{(8-EXP_W){exp_q[EXP_W-1]}}, exp_q} + {4'd0, nd} - 8'd1;
                state_d  = S_DONE;
            end
            default: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset also aborts a conversion in flight; no valid follows it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prev_q   <= 1'b0;
            sign_q   <= 1'b0;
            mant_q   <= '0;
            exp_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            osign_q  <= 1'b0;
            digits_q <= '0;
            nd_q     <= '0;
            eout_q   <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= start;
            sign_q   <= sign_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            osign_q  <= osign_d;
            digits_q <= digits_d;
            nd_q     <= nd_d;
            eout_q   <= eout_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign valid   = valid_q;
    assign signOut = osign_q;
    assign digits  = digits_q;
    assign nDigits = nd_q;
    assign expOut  = eout_q;
    assign isZero  = zero_q;
endmodule

// File: tb/tb_result_formatter.sv
// tb_result_formatter: directed scoreboard bench for result_formatter
module tb_result_formatter;
    import calc_pkg::*;

    typedef struct {
        logic        sign;
        logic [43:0] digits;
        logic [3:0]  nd;
        logic [7:0]  eo;
        logic        zero;
        int          go;
    } exp_t;

    logic        clock = 0, reset = 1, start = 0, signIn = 0;
    logic [33:0] mantIn = '0;
    logic [6:0]  expIn = '0;
    logic        busy, valid, signOut, isZero;
    logic [43:0] digits;
    logic [3:0]  nDigits;
    logic [7:0]  expOut;

    exp_t q[$];
    exp_t e;
    int   ncmp = 0, nbad = 0, nvalid = 0, npush = 0, cyc = 0;

    result_formatter dut (
        .clock(clock), .reset(reset), .start(start), .signIn(signIn),
        .mantIn(mantIn), .expIn(expIn), .busy(busy), .valid(valid),
        .signOut(signOut), .digits(digits), .nDigits(nDigits),
        .expOut(expOut), .isZero(isZero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [33:0] m, input logic signed [6:0] x);
        exp_t   r;
        longint v;
        int     n;
        v = longint'(m);
        r.digits = '0;
        for (int i = 0; i < 11; i++) begin
            r.digits[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        v = longint'(m);
        n = 0;
        while (v > 0) begin
            n++;
            v = v / 10;
        end
        r.zero = (m == 0);
        r.nd   = r.zero ? 4'd1 : 4'(n);
        r.sign = s & ~r.zero;
        r.eo   = r.zero ? 8'd0 : 8'(int'(x) + n - 1);
        r.go   = 0;
        return r;
    endfunction

    task automatic launch(input logic s, input logic [33:0] m, input logic signed [6:0] x,
                          input bit push, input bit hold);
        exp_t r;
        @(negedge clock);
        signIn = s;
        mantIn = m;
        expIn  = x;
        start  = 1;
        if (push) begin
            r    = model(s, m, x);
            r.go = cyc + 1;
            q.push_back(r);
            npush++;
        end
        @(negedge clock);
        if (!hold) start = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clock);
        check("timeout", 64'(q.size()), 0);
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        #1;
        if (valid) begin
            nvalid++;
            if (q.size() == 0) check("spurious_valid", 64'(valid), 0);
            else begin
                e = q.pop_front();
                check("latency", 64'(cyc), 64'(e.go + 36));
                check("digits", 64'(digits), 64'(e.digits));
                check("nDigits", 64'(nDigits), 64'(e.nd));
                check("expOut", 64'(expOut), 64'(e.eo));
                check("signOut", 64'(signOut), 64'(e.sign));
                check("isZero", 64'(isZero), 64'(e.zero));
                check("busy_at_valid", 64'(busy), 0);
            end
        end
    end

    initial begin
        logic [33:0] q3;
        repeat (2) @(negedge clock);
        reset = 0;
        check("rst_digits", 64'(digits), 0);
        check("rst_nDigits", 64'(nDigits), 0);
        check("rst_expOut", 64'(expOut), 0);
        check("rst_valid", 64'(valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_sign_zero", 64'({signOut, isZero}), 0);

        launch(0, 34'd12345, -7'sd3, 1, 0);
        check("busy_after_go", 64'(busy), 1);
        wait_idle();
        launch(1, M_MAX, 7'sd63, 1, 0);
        wait_idle();
        launch(1, 34'd0, 7'sd5, 1, 0);
        wait_idle();
        launch(0, 34'd7, -7'sd64, 1, 0);
        wait_idle();

        launch(0, 34'd4096, 7'sd2, 1, 1);
        repeat (99) @(negedge clock);
        start = 0;
        wait_idle();

        launch(1, 34'd86420, -7'sd10, 1, 0);
        repeat (9) @(negedge clock);
        launch(0, 34'd55555, 7'sd9, 0, 0);
        wait_idle();

        launch(0, 34'd999, 7'sd0, 1, 0);
        repeat (19) @(negedge clock);
        @(posedge clock);
        #1 reset = 1;
        @(negedge clock);
        q.delete();
        npush--;
        check("abort_digits", 64'(digits), 0);
        check("abort_nDigits", 64'(nDigits), 0);
        check("abort_expOut", 64'(expOut), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_valid", 64'(valid), 0);
        reset = 0;
        repeat (50) @(negedge clock);
        launch(0, 34'd1000, 7'sd0, 1, 0);
        wait_idle();

        q3 = 34'(64'd10000000000 / 3);
        launch(0, q3, -7'sd10, 1, 0);
        wait_idle();

        repeat (5) @(negedge clock);
        check("valid_count", 64'(nvalid), 64'(npush));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
